// File: rtl/cascade_display_if.sv
// cascade_display_if: counter-side inputs and display-side outputs of the cascade display stage
interface cascade_display_if;
    logic [3:0] q_in;
    logic       qcc_in;
    logic       mode_in;
    logic       ld_in;
    logic [3:0] hi_ld;
    logic [3:0] hi;
    logic       ovf;
    logic [6:0] seg;
    logic [1:0] an;
    modport master (output q_in, qcc_in, mode_in, ld_in, hi_ld, input hi, ovf, seg, an);
    modport slave (input q_in, qcc_in, mode_in, ld_in, hi_ld, output hi, ovf, seg, an);
endinterface

// File: rtl/cascade_display.sv
// cascade_display: cascaded high hex digit plus 2-digit multiplexed 7-segment driver; LEADING_ZERO_BLANK_EN darkens a zero high digit
module cascade_display #(
    parameter int SCAN_DIV = 50000
) (
    input logic         clk,
    input logic         clr,
    cascade_display_if.slave bus
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    logic [2:0]    qcc_q, qcc_d;
    logic [1:0]    mode_q, mode_d, ld_q, ld_d;
    logic [3:0]    hi_q, hi_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          fall, wrap;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // synchronisers: bit 0 is the first stage; qcc gets a third stage for edge detection
    always_comb begin
        qcc_d  = {qcc_q[1:0], bus.qcc_in};
        mode_d = {mode_q[0], bus.mode_in};
        ld_d   = {ld_q[0], bus.ld_in};
        fall   = qcc_q[2] & ~qcc_q[1];
    end

    // high digit: load beats count, a fall event steps in the synced direction
    always_comb begin
        hi_d  = hi_q;
        ovf_d = 1'b0;
        if (!ld_q[1]) begin
            hi_d = bus.hi_ld;
        end else if (fall) begin
            hi_d  = mode_q[1] ? hi_q + 4'd1 : hi_q - 4'd1;
            ovf_d = mode_q[1] ? (hi_q == 4'hF) : (hi_q == 4'h0);
        end
    end

    // scan timer and registered digit drive from the current slot
    always_comb begin
        wrap  = cnt_q == CW'(SCAN_DIV - 1);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        sel_d = sel_q ^ wrap;
        an_d  = sel_q ? 2'b01 : 2'b10;
        seg_d = hex7(sel_q ? hi_q : bus.q_in);
`ifdef LEADING_ZERO_BLANK_EN
        if (sel_q && hi_q == 4'h0) begin
            an_d  = 2'b11;
            seg_d = 7'h7F;
        end
`endif
    end

    // all state; sync flops reset to the idle (high) level so release makes no false edge
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            qcc_q  <= 3'b111;
            mode_q <= 2'b11;
            ld_q   <= 2'b11;
            hi_q   <= 4'h0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            sel_q  <= 1'b0;
            seg_q  <= 7'h7F;
            an_q   <= 2'b11;
        end else begin
            qcc_q  <= qcc_d;
            mode_q <= mode_d;
            ld_q   <= ld_d;
            hi_q   <= hi_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign bus.hi  = hi_q;
    assign bus.ovf = ovf_q;
    assign bus.seg = seg_q;
    assign bus.an  = an_q;
endmodule
